// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes mirror the instruction decode; states are the unit's sequencer.
package mdu_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    assign dout = neg ? -din : din;

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU on magnitudes with a final sign correction into HI/LO.
// Latency: done in the cycle after edge WIDTH+1 counted from the start edge.
// Backpressure: start is ignored while busy; the caller stalls on busy.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    state_e             state_q, state_d;
    logic [2*WIDTH:0]   acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_div_q, sign_a_q, sign_b_q, b_zero_q;

    logic               is_signed, is_div_in, sign_a_in, sign_b_in;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign is_div_in = (op == OP_DIV)  || (op == OP_DIVU);
    assign sign_a_in = is_signed & a[WIDTH-1];
    assign sign_b_in = is_signed & b[WIDTH-1];

    mdu_sign_fix #(.W(WIDTH)) u_mag_a (.neg(sign_a_in), .din(a), .dout(a_mag));
    mdu_sign_fix #(.W(WIDTH)) u_mag_b (.neg(sign_b_in), .din(b), .dout(b_mag));

    // One shift-add (multiply) or restoring shift-subtract (divide) step.
    logic [2*WIDTH:0]   mul_next, div_next;
    logic [WIDTH:0]     mul_sum, rem_sh;
    logic [WIDTH-1:0]   trial;
    logic               no_borrow;

    always_comb begin
        mul_sum   = acc_q[2*WIDTH:WIDTH] + {1'b0, opnd_q};
        mul_next  = acc_q[0] ? {1'b0, mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH:1]};
        rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
        no_borrow = rem_sh >= {1'b0, opnd_q};
        trial     = rem_sh[WIDTH-1:0] - opnd_q;
        div_next  = {1'b0, (no_borrow ? trial : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], no_borrow};
    end

    logic               neg_res;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed, rem_fixed;

    assign neg_res = sign_a_q ^ sign_b_q;

    mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (.neg(neg_res),  .din(acc_q[2*WIDTH-1:0]),     .dout(prod_fixed));
    mdu_sign_fix #(.W(WIDTH))   u_fix_quo  (.neg(neg_res),  .din(acc_q[WIDTH-1:0]),       .dout(quo_fixed));
    mdu_sign_fix #(.W(WIDTH))   u_fix_rem  (.neg(sign_a_q), .din(acc_q[2*WIDTH-1:WIDTH]), .dout(rem_fixed));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    is_div_q <= is_div_in;
                    sign_a_q <= sign_a_in;
                    sign_b_q <= sign_b_in;
                    b_zero_q <= (b == '0);
                    opnd_q   <= is_div_in ? b_mag : a_mag;
                    acc_q    <= {{(WIDTH+1){1'b0}}, (is_div_in ? a_mag : b_mag)};
                    cnt_q    <= '0;
                end
                CALC: begin
                    acc_q <= is_div_q ? div_next : mul_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                FIX: begin
                    if (is_div_q) begin
                        // With a zero divisor the remainder path shifts the whole dividend
                        // in, so the sign-corrected remainder is exactly a as sampled.
                        lo       <= b_zero_q ? '1 : quo_fixed;
                        hi       <= rem_fixed;
                        div_zero <= b_zero_q;
                    end else begin
                        {hi, lo} <= prod_fixed;
                        div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed-vector bench for mdu_iter: results, latency, busy/done framing,
// start-while-busy immunity and asynchronous reset mid-operation.
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op and check result, latency and busy/done framing.
    // With disturb set, start is pulsed with different operands mid-CALC.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input logic exp_dz, input bit disturb);
        int  n;
        bit  seen;
        bit  busy_ok;
        @(negedge clk);
        op = o; a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        busy_ok = busy;
        seen    = 1'b0;
        n       = 0;
        for (int i = 1; i <= 100; i++) begin
            if (disturb && i == 10) begin
                start = 1'b1; op = OP_DIVU; a = ~av; b = bv + 1;
            end
            if (disturb && i == 11) start = 1'b0;
            @(posedge clk); #1;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                n    = i;
                seen = 1'b1;
                break;
            end
        end
        chk({tag, " done_seen"}, 64'(seen), 64'd1);
        chk({tag, " latency"},   64'(n), 64'(W + 1));
        chk({tag, " busy"},      64'(busy_ok), 64'd1);
        chk({tag, " hi"},        64'(hi), 64'(exp_hi));
        chk({tag, " lo"},        64'(lo), 64'(exp_lo));
        chk({tag, " div_zero"},  64'(div_zero), 64'(exp_dz));
        @(posedge clk); #1;
        chk({tag, " done_pulse"}, {62'd0, done, busy}, 64'd0);
        chk({tag, " hold"}, {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", {59'd0, busy, done, div_zero, |hi, |lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        run_op("mult_neg",   OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
        run_op("mult_min",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
        run_op("div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op("divu_7_2",   OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         1'b0, 1'b0);
        run_op("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op("divu_zero",  OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("multu_2_3",  OP_MULTU, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0, 1'b0);
        run_op("div_negb",   OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op("disturb",    OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
        run_op("div_zero_s", OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Reset in the middle of CALC, with nonzero hi/lo/div_zero held from above.
        @(negedge clk);
        op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset done", 64'(done), 64'd0);
        chk("midreset hilo", {hi, lo}, 64'd0);
        chk("midreset dz",   64'(div_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("after_rst",  OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
